// File: rtl/srl32_iter.sv
// Multi-cycle iterative right shifter (logical / arithmetic), up to STEP bits per cycle.
// Operands follow sll32: A holds the shift amount, B holds the data.
module srl32_iter #(
    parameter int unsigned STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        arith,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [4:0] STEP5 = 5'(STEP);

    logic [1:0]  state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        fill_q, fill_d;

    logic        last_step;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic        unused_a_hi;

    assign unused_a_hi = ^A[31:5];

    // fill_q holds the actual vacated-bit value (arith & B[31]), not just the mode flag.
    assign last_step = (cnt_q <= STEP5);
    assign shamt     = last_step ? cnt_q : STEP5;
    assign shifted   = 32'({{32{fill_q}}, data_q} >> shamt);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d  = B;
                    cnt_d   = A[4:0];
                    fill_d  = arith & B[31];
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = shifted;
                if (last_step) begin
                    res_d   = shifted;
                    cnt_d   = 5'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - STEP5;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= 32'd0;
            res_q   <= 32'd0;
            cnt_q   <= 5'd0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign res  = res_q;

endmodule

// File: tb/tb_srl32_iter.sv
// Randomized self-checking bench for srl32_iter against a plain-arithmetic shift model.
module tb_srl32_iter;

    localparam int unsigned STEP = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        arith;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int n_vec;
    int n_err;
    logic [31:0] model_res;

    srl32_iter #(.STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .arith (arith),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                               input logic ar);
        int n;
        logic [31:0] r;
        n = int'(a[4:0]);
        if (ar) r = 32'($signed(b) >>> n);
        else    r = b >> n;
        return r;
    endfunction

    function automatic int ref_lat(input logic [31:0] a);
        int n;
        n = int'(a[4:0]);
        return (n == 0) ? 1 : (n + int'(STEP) - 1) / int'(STEP);
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 in the first idle cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ar,
                          input bit noisy);
        logic [31:0] exp_res;
        int exp_lat;
        int lat;
        int busy_cycles;
        exp_res     = ref_shift(a, b, ar);
        exp_lat     = ref_lat(a);
        A           = a;
        B           = b;
        arith       = ar;
        start       = 1'b1;
        lat         = 0;
        busy_cycles = 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (noisy) begin
                start = 1'b1;
                A     = 32'd1;
                B     = 32'd0;
                arith = 1'($urandom);
            end
            if (busy) busy_cycles++;
            if (done) begin
                lat = k - 1;
                break;
            end
            check("res_stable_in_shift", res, model_res);
            @(posedge clk); #1;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", res, exp_res);
        check("busy_in_done", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check("done_pulse_len", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        check("res_hold", res, exp_res);
        check("busy_cycles", 32'(busy_cycles), 32'(exp_lat + 1));
        model_res = exp_res;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        model_res = 32'd0;
        rst_n     = 1'b0;
        start     = 1'b0;
        arith     = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_res", res, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'd3, 32'h0000_0400, 1'b0, 1'b0);
        run_op(32'd4, 32'h8000_0000, 1'b1, 1'b0);
        run_op(32'd4, 32'h8000_0000, 1'b0, 1'b0);
        run_op(32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(32'd31, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'd32, 32'h1234_5678, 1'b0, 1'b0);
        run_op(32'hFFFF_FFE8, 32'h1234_5678, 1'b0, 1'b0);
        run_op(32'd8, 32'hDEAD_BEEF, 1'b1, 1'b1);
        run_op(32'd0, 32'h8765_4321, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a 5-step shift.
        A     = 32'd20;
        B     = 32'hF0F0_1234;
        arith = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_res", res, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        model_res = 32'd0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("no_done_after_abort", {30'd0, busy, done}, 32'd0);
        end
        run_op(32'd20, 32'hF0F0_1234, 1'b1, 1'b0);

        for (int i = 0; i < 150; i++) begin
            run_op($urandom, $urandom, 1'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
